// File: rtl/handshake_packer.sv
// handshake_packer: gathers RATIO narrow beats of A bits into one wide word.
// Both sides use a valid/ready handshake. The output side is a single
// registered word with a full flag.
// Optional early close with a keep mask: define HANDSHAKE_PACKER_LAST_EN.
// That adds the last_i and keep_o ports. Without it, every word carries
// exactly RATIO beats.
module handshake_packer #(
    parameter int A     = 3,
    parameter int RATIO = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [A-1:0]         din,
`ifdef HANDSHAKE_PACKER_LAST_EN
    input  logic                 last_i,
    output logic [RATIO-1:0]     keep_o,
`endif
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [A*RATIO-1:0]   dout
);

    localparam int W  = A * RATIO;
    localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic [W-1:0]  acc;
    logic [CW-1:0] cnt;
    logic          full;
    logic          accept;
    logic          out_xfer;
    logic          at_last_lane;
    logic          complete;
    logic [W-1:0]  merged;
`ifdef HANDSHAKE_PACKER_LAST_EN
    logic [RATIO-1:0] keep_next;
`endif

    // Accept depends only on the registered full flag and downstream ready,
    // so there is no combinational path from valid_i to ready_o.
    assign ready_o      = ~full | ready_i;
    assign valid_o      = full;
    assign accept       = valid_i & ready_o;
    assign out_xfer     = full & ready_i;
    assign at_last_lane = (cnt == CW'(RATIO - 1));

`ifdef HANDSHAKE_PACKER_LAST_EN
    assign complete = accept & (at_last_lane | last_i);
`else
    assign complete = accept & at_last_lane;
`endif

    // Word to load on completion: lanes below cnt come from acc, and the
    // current beat goes into lane cnt. Lanes above cnt are zeroed
    // explicitly, so a short word never carries stale data.
    always_comb begin
        merged = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (CW'(i) < cnt) begin
                merged[i*A +: A] = acc[i*A +: A];
            end else if (CW'(i) == cnt) begin
                merged[i*A +: A] = din;
            end
        end
    end

`ifdef HANDSHAKE_PACKER_LAST_EN
    // Keep mask for the word being closed: ones in lanes 0..cnt.
    always_comb begin
        keep_next = '0;
        for (int i = 0; i < RATIO; i++) begin
            keep_next[i] = (CW'(i) <= cnt);
        end
    end
`endif

    // Accumulator, lane counter and output register. A completing beat
    // reloads the output in the same cycle the previous word leaves, so
    // full stays high with no bubble.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            acc    <= '0;
            cnt    <= '0;
            full   <= 1'b0;
            dout   <= '0;
`ifdef HANDSHAKE_PACKER_LAST_EN
            keep_o <= '0;
`endif
        end else begin
            if (complete) begin
                dout   <= merged;
`ifdef HANDSHAKE_PACKER_LAST_EN
                keep_o <= keep_next;
`endif
                full   <= 1'b1;
                cnt    <= '0;
                acc    <= '0;
            end else begin
                if (accept) begin
                    acc[cnt*A +: A] <= din;
                    cnt             <= cnt + CW'(1);
                end
                if (out_xfer) begin
                    full <= 1'b0;
                end
            end
        end
    end

endmodule
